// File: rtl/reg_file_mp.sv
// reg_file_mp: register file with two write ports and two asynchronous read ports.
// After reset, a CLEAR sequence zeroes entries 1..DEPTH-1, one entry per clock.
// busy is high during this sequence. Entry 0 always reads as zero.
// Port 2 wins when both write ports target the same address.
// Optional macro REG_FILE_BYPASS_EN: enabled writes are forwarded to the read
// ports in the same cycle. When it is undefined, reads return the stored contents.
//
// state   | meaning
// --------+----------------------------------------------------------
// S_CLEAR | zeroing entry clr_idx each clock; writes ignored, reads 0
// S_READY | normal operation

module reg_file_mp #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rstd,
    input  logic [ADDR_W-1:0] wa1,
    input  logic [ADDR_W-1:0] wa2,
    input  logic [DATA_W-1:0] wd1,
    input  logic [DATA_W-1:0] wd2,
    input  logic              we1_n,
    input  logic              we2_n,
    input  logic [ADDR_W-1:0] ra1,
    input  logic [ADDR_W-1:0] ra2,
    output logic [DATA_W-1:0] rr1,
    output logic [DATA_W-1:0] rr2,
    output logic              busy
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W-1:0] FIRST_IDX = ADDR_W'(1);

    typedef enum logic {
        S_CLEAR = 1'b0,
        S_READY = 1'b1
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [ADDR_W-1:0] clr_idx;
    logic [DATA_W-1:0] mem [DEPTH];

    // State register: reset always restarts the clear sequence.
    always_ff @(posedge clk or negedge rstd) begin
        if (!rstd) begin
            state <= S_CLEAR;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state: leave CLEAR on the clock that clears the last entry.
    always_comb begin
        state_nxt = state;
        case (state)
            S_CLEAR: if (clr_idx == LAST_IDX) state_nxt = S_READY;
            S_READY: state_nxt = S_READY;
            default: state_nxt = S_CLEAR;
        endcase
    end

    // Output decode.
    always_comb begin
        busy = (state == S_CLEAR);
    end

    // Clear index: it starts at 1, because entry 0 is hardwired to zero.
    // It holds at the last entry instead of wrapping.
    always_ff @(posedge clk or negedge rstd) begin
        if (!rstd) begin
            clr_idx <= FIRST_IDX;
        end else if (state == S_CLEAR && clr_idx != LAST_IDX) begin
            clr_idx <= clr_idx + 1'b1;
        end
    end

    // Storage array, with no reset. While rstd is low, the state is CLEAR,
    // so user writes are dropped. Only the zero write to clr_idx (entry 1) can occur.
    // The later statement takes priority, so port 2 wins a same-address collision.
    always_ff @(posedge clk) begin
        if (state == S_CLEAR) begin
            mem[clr_idx] <= '0;
        end else begin
            if (!we1_n && wa1 != '0) mem[wa1] <= wd1;
            if (!we2_n && wa2 != '0) mem[wa2] <= wd2;
        end
    end

    function automatic logic [DATA_W-1:0] read_port(input logic [ADDR_W-1:0] ra);
        logic [DATA_W-1:0] val;
        val = mem[ra];
`ifdef REG_FILE_BYPASS_EN
        if (!we1_n && wa1 == ra) val = wd1;
        if (!we2_n && wa2 == ra) val = wd2;
`endif
        if (busy || ra == '0) val = '0;
        return val;
    endfunction

    // Read port 1: combinational, zero latency.
    always_comb begin
        rr1 = read_port(ra1);
    end

    // Read port 2: combinational, zero latency.
    always_comb begin
        rr2 = read_port(ra2);
    end

endmodule

// File: tb/tb_reg_file_mp.sv
// Testbench for reg_file_mp. The driver applies inputs on each falling edge.
// At the same moment it pushes the expected read data and busy value,
// computed by an array-based reference model. A monitor samples the outputs
// shortly afterwards and compares them against the scoreboard queue.
// Forwarding expectations follow REG_FILE_BYPASS_EN.

module tb_reg_file_mp;

    localparam int DW    = 32;
    localparam int AW    = 5;
    localparam int DEPTH = 32;

    logic          clk = 1'b0;
    logic          rstd;
    logic [AW-1:0] wa1, wa2, ra1, ra2;
    logic [DW-1:0] wd1, wd2, rr1, rr2;
    logic          we1_n, we2_n, busy;

    always #5 clk = ~clk;

    reg_file_mp #(.DATA_W(DW), .ADDR_W(AW)) dut (
        .clk   (clk),
        .rstd  (rstd),
        .wa1   (wa1),
        .wa2   (wa2),
        .wd1   (wd1),
        .wd2   (wd2),
        .we1_n (we1_n),
        .we2_n (we2_n),
        .ra1   (ra1),
        .ra2   (ra2),
        .rr1   (rr1),
        .rr2   (rr2),
        .busy  (busy)
    );

    typedef struct {
        logic [DW-1:0] rr1;
        logic [DW-1:0] rr2;
        logic          busy;
    } exp_t;

    exp_t          sb_q[$];
    int            n_checks = 0;
    int            n_errors = 0;

    // Reference model: the stored contents, plus the number of clear clocks
    // still to run (zero means the file is ready).
    logic [DW-1:0] mdl_mem [DEPTH];
    int            clr_left = DEPTH - 1;

    function automatic logic [DW-1:0] mdl_read(input logic [AW-1:0] a);
        if (clr_left > 0 || a == 0) return '0;
`ifdef REG_FILE_BYPASS_EN
        if (!we2_n && wa2 == a) return wd2;
        if (!we1_n && wa1 == a) return wd1;
`endif
        return mdl_mem[a];
    endfunction

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Runs one clock cycle of stimulus, queues the expectation, and advances the model.
    task automatic cyc(input logic r,
                       input logic w1n, input logic [AW-1:0] a1, input logic [DW-1:0] d1,
                       input logic w2n, input logic [AW-1:0] a2, input logic [DW-1:0] d2,
                       input logic [AW-1:0] q1, input logic [AW-1:0] q2);
        exp_t e;
        @(negedge clk);
        rstd = r; we1_n = w1n; wa1 = a1; wd1 = d1;
        we2_n = w2n; wa2 = a2; wd2 = d2; ra1 = q1; ra2 = q2;
        if (!r) clr_left = DEPTH - 1;
        e.rr1  = mdl_read(q1);
        e.rr2  = mdl_read(q2);
        e.busy = (clr_left > 0);
        sb_q.push_back(e);
        @(posedge clk);
        if (r) begin
            if (clr_left > 0) begin
                clr_left--;
                if (clr_left == 0)
                    for (int i = 0; i < DEPTH; i++) mdl_mem[i] = '0;
            end else begin
                if (!w1n && a1 != 0) mdl_mem[a1] = d1;
                if (!w2n && a2 != 0) mdl_mem[a2] = d2;
            end
        end
    endtask

    task automatic cyc_rand(input logic r);
        logic [AW-1:0] a1, a2, q1, q2;
        a1 = AW'($urandom);
        a2 = ($urandom_range(0, 3) == 0) ? a1 : AW'($urandom);
        q1 = ($urandom_range(0, 2) == 0) ? a1 : AW'($urandom);
        q2 = ($urandom_range(0, 2) == 0) ? a2 : AW'($urandom);
        cyc(r, 1'($urandom), a1, $urandom, 1'($urandom), a2, $urandom, q1, q2);
    endtask

    // Monitor: the outputs are valid every cycle and are sampled mid-low-phase.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                check("busy", {31'd0, busy}, {31'd0, e.busy});
                check("rr1", rr1, e.rr1);
                check("rr2", rr2, e.rr2);
            end
        end
    end

    initial begin
        rstd = 1'b0; we1_n = 1'b1; we2_n = 1'b1;
        wa1 = '0; wa2 = '0; wd1 = '0; wd2 = '0; ra1 = '0; ra2 = '0;

        // Reset held while writes are attempted.
        repeat (3) cyc(1'b0, 1'b0, 5'd3, 32'hAAAA_5555, 1'b0, 5'd4, 32'h1234_5678, 5'd3, 5'd4);

        // Release, and sweep the reads through the clear and afterwards.
        for (int i = 0; i < DEPTH; i++)
            cyc(1'b1, 1'b1, '0, '0, 1'b1, '0, '0, AW'(i), AW'(DEPTH - 1 - i));
        for (int i = 0; i < DEPTH; i++)
            cyc(1'b1, 1'b1, '0, '0, 1'b1, '0, '0, AW'(i), AW'(i));

        // Single write and readback.
        cyc(1'b1, 1'b0, 5'd5, 32'hDEAD_BEEF, 1'b1, '0, '0, 5'd5, 5'd5);
        cyc(1'b1, 1'b1, '0, '0, 1'b1, '0, '0, 5'd5, 5'd6);

        // Same-address collision: port 2 wins.
        cyc(1'b1, 1'b0, 5'd7, 32'h1, 1'b0, 5'd7, 32'h2, 5'd7, 5'd7);
        cyc(1'b1, 1'b1, '0, '0, 1'b1, '0, '0, 5'd5, 5'd7);

        // Writes to entry 0 are discarded.
        cyc(1'b1, 1'b0, 5'd0, 32'hFFFF_FFFF, 1'b0, 5'd0, 32'hFFFF_FFFF, 5'd0, 5'd0);
        cyc(1'b1, 1'b1, '0, '0, 1'b1, '0, '0, 5'd0, 5'd0);

        // Write and read the same address in the same cycle.
        cyc(1'b1, 1'b0, 5'd9, 32'h55, 1'b1, '0, '0, 5'd9, 5'd9);
        cyc(1'b1, 1'b1, '0, '0, 1'b1, '0, '0, 5'd9, 5'd9);

        // Abort the clear at index 10, with writes issued throughout.
        cyc(1'b0, 1'b1, '0, '0, 1'b1, '0, '0, 5'd9, 5'd5);
        repeat (9) cyc_rand(1'b1);
        cyc(1'b0, 1'b0, 5'd11, 32'hCAFE_F00D, 1'b0, 5'd12, 32'hBEEF_CAFE, 5'd11, 5'd12);
        repeat (DEPTH + 2) cyc_rand(1'b1);
        for (int i = 0; i < DEPTH; i++)
            cyc(1'b1, 1'b1, '0, '0, 1'b1, '0, '0, AW'(i), AW'(i));

        // Random traffic, with an occasional reset.
        repeat (3000) cyc_rand(($urandom_range(0, 299) == 0) ? 1'b0 : 1'b1);

        for (int k = 0; k < 20 && sb_q.size() > 0; k++) @(negedge clk);
        #3;
        if (sb_q.size() > 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL drain: %0d expectations left, expected 0", sb_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/reg_file_mp.md
REG_FILE_MP -- requirements
Module: reg_file_mp

Interface
REQ-001 SHALL provide parameter DATA_W, default 32: width of each register in bits.
REQ-002 SHALL provide parameter ADDR_W, default 5: address width; DEPTH = 2**ADDR_W registers.
REQ-003 SHALL provide port clk  input  1  clock; all state changes on rising edge.
REQ-004 SHALL provide port rstd  input  1  reset, asynchronous, active-low.
REQ-005 SHALL provide ports wa1, wa2  input  ADDR_W  write addresses, ports 1 and 2.
REQ-006 SHALL provide ports wd1, wd2  input  DATA_W  write data, ports 1 and 2.
REQ-007 SHALL provide ports we1_n, we2_n  input  1  write enables, active-low (0 = write).
REQ-008 SHALL provide ports ra1, ra2  input  ADDR_W  read addresses.
REQ-009 SHALL provide ports rr1, rr2  output  DATA_W  combinational read data.
REQ-010 SHALL provide port busy  output  1  high while reset or the clear sequence is in progress.

Function
REQ-011 SHALL implement a two-state FSM: CLEAR and READY.
REQ-012 In CLEAR, SHALL write zero to entry clr_idx each clock, starting at 1 and incrementing by 1.
REQ-013 SHALL go from CLEAR to READY on the clock that clears entry DEPTH-1; clr_idx SHALL NOT wrap.
REQ-014 busy SHALL be 1 in CLEAR and 0 in READY; the clear takes DEPTH-1 clocks after rstd rises (31 for defaults).
REQ-015 While busy=1, SHALL ignore we1_n/we2_n and drive rr1=rr2=0.
REQ-016 In READY, SHALL write wdN to entry waN on a rising clk edge when weN_n=0.
REQ-017 Entry 0 SHALL always read as 0; writes addressed to 0 SHALL be discarded.
REQ-018 Simultaneous writes to the same address SHALL store wd2 (port 2 wins).
REQ-019 Reads SHALL be asynchronous with zero latency: rrN reflects raN in the same cycle.
REQ-020 Both read ports SHALL be usable on the same or different addresses in any cycle.
REQ-021 Forwarding rules are set by the bypass configuration (REQ-027, REQ-028).

Reset
REQ-022 rstd=0 SHALL asynchronously force state=CLEAR, clr_idx=1 and busy=1; rr1=rr2=0 follows from REQ-015.
REQ-023 Register array contents SHALL NOT be reset asynchronously; they are zeroed only by the CLEAR sequence.
REQ-024 rstd asserted mid-clear or mid-write SHALL abort the operation and restart the clear from entry 1 after release.
REQ-025 A write presented on the clock edge coincident with rstd=0 SHALL be discarded.

Configuration
REQ-026 Macro REG_FILE_BYPASS_EN SHALL select write-to-read forwarding.
REQ-027 With REG_FILE_BYPASS_EN defined and busy=0:
- rrN SHALL return the write data in the same cycle when raN equals an enabled write address and raN != 0.
- When both write ports target raN, wd2 SHALL be returned.
REQ-028 Without REG_FILE_BYPASS_EN, rrN SHALL return the stored value; the new value becomes visible the cycle after the write edge.

Verification
REQ-029 Release rstd, poll busy -> busy=1 for exactly 31 clocks, then 0; every ra1 0..31 reads 0.
REQ-030 Write wa1=5, wd1=0xDEADBEEF, we1_n=0; next cycle ra1=5 -> rr1=0xDEADBEEF.
REQ-031 wa1=wa2=7, wd1=0x1, wd2=0x2, both enabled -> next cycle ra2=7 returns 0x2.
REQ-032 Write 0xFFFFFFFF to address 0 -> ra1=0 and ra2=0 both return 0.
REQ-033 Write wa1=9, wd1=0x55 with ra1=9 in the same cycle:
- With REG_FILE_BYPASS_EN: rr1=0x55 before the edge.
- Without it: rr1 holds the old value until after the edge.
REQ-034 Assert rstd=0 at clear index 10 -> busy stays 1, clear restarts at 1, full 31-clock sequence completes, writes issued meanwhile are ignored.
